// File: rtl/time_keeper_pkg.sv
// Shared digit limits, widths and the entry-bus validity check for the
// time_keeper clock core.
package time_keeper_pkg;

    localparam int SEC_TENS_MAX         = 5;
    localparam int MIN_TENS_MAX         = 5;
    localparam int DIGIT_MAX            = 9;
    localparam int HOUR_TENS_MAX        = 2;
    localparam int HOUR_UNITS_MAX_AT_20 = 3;

    localparam int HOUR_TENS_W = 2;
    localparam int DIGIT_W     = 4;

    // True when the entry bus holds a legal 24-hour HH:MM value.
    function automatic logic entry_valid(
        input logic [HOUR_TENS_W-1:0] h1,
        input logic [DIGIT_W-1:0]     h0,
        input logic [DIGIT_W-1:0]     m1,
        input logic [DIGIT_W-1:0]     m0
    );
        logic ok;
        ok = (h1 <= HOUR_TENS_W'(HOUR_TENS_MAX))
          && (h0 <= DIGIT_W'(DIGIT_MAX))
          && (m1 <= DIGIT_W'(MIN_TENS_MAX))
          && (m0 <= DIGIT_W'(DIGIT_MAX));
        if (h1 == HOUR_TENS_W'(HOUR_TENS_MAX) && h0 > DIGIT_W'(HOUR_UNITS_MAX_AT_20))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/time_keeper_bcd_digit_cnt.sv
// Single BCD digit counter, 0..MAX, with synchronous load and a carry that
// fires on the increment which wraps MAX back to 0.
module bcd_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry_out
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_reg, value_next;

    always_comb begin
        value_next = value_reg;
        if (load)
            value_next = load_val;
        else if (inc)
            value_next = (value_reg == MAX_V) ? '0 : value_reg + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            value_reg <= '0;
        else
            value_reg <= value_next;
    end

    assign value     = value_reg;
    assign carry_out = inc && !load && (value_reg == MAX_V);

endmodule

// File: rtl/time_keeper.sv
// Running BCD time of day plus stored alarm time, advanced by a 1 s tick
// divided down from clk; set through a shared, validated digit entry bus.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [HOUR_TENS_W-1:0] H_in1,
    input  logic [DIGIT_W-1:0]     H_in0,
    input  logic [DIGIT_W-1:0]     M_in1,
    input  logic [DIGIT_W-1:0]     M_in0,
    input  logic                   LD_time,
    input  logic                   LD_alarm,
    output logic [HOUR_TENS_W-1:0] c_hour1,
    output logic [DIGIT_W-1:0]     c_hour0,
    output logic [DIGIT_W-1:0]     c_min1,
    output logic [DIGIT_W-1:0]     c_min0,
    output logic [DIGIT_W-1:0]     c_sec1,
    output logic [DIGIT_W-1:0]     c_sec0,
    output logic [HOUR_TENS_W-1:0] a_hour1,
    output logic [DIGIT_W-1:0]     a_hour0,
    output logic [DIGIT_W-1:0]     a_min1,
    output logic [DIGIT_W-1:0]     a_min0,
    output logic                   one_sec,
    output logic                   ld_err
);

    localparam int            PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic          tick, entry_ok, load_time, load_alarm, load_req;
    logic          one_sec_reg, one_sec_next, ld_err_reg, ld_err_next;

    assign entry_ok   = entry_valid(H_in1, H_in0, M_in1, M_in0);
    assign load_req   = LD_time || LD_alarm;
    assign load_time  = LD_time && entry_ok;
    assign load_alarm = LD_alarm && entry_ok;
    assign tick       = (presc_reg == PRESC_LAST);

    // A valid time load restarts the second, so the prescaler is parked at 0.
    always_comb begin
        presc_next = presc_reg + PW'(1);
        if (load_time || tick)
            presc_next = '0;
        one_sec_next = (presc_next == PRESC_LAST);
        ld_err_next  = load_req && !entry_ok;
    end

    // Ripple chain: sec0, sec1, min0, min1; loading time clears the seconds.
    logic [DIGIT_W-1:0] dig_val      [4];
    logic [DIGIT_W-1:0] dig_load_val [4];
    logic [3:0]         dig_inc, dig_carry;

    assign dig_load_val[0] = '0;
    assign dig_load_val[1] = '0;
    assign dig_load_val[2] = M_in0;
    assign dig_load_val[3] = M_in1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam int DMAX = (gi == 1) ? SEC_TENS_MAX :
                                  (gi == 3) ? MIN_TENS_MAX : DIGIT_MAX;
            if (gi == 0) begin : g_first
                assign dig_inc[gi] = tick && !load_time;
            end else begin : g_chain
                assign dig_inc[gi] = dig_carry[gi-1];
            end
            bcd_digit_cnt #(
                .MAX (DMAX),
                .W   (DIGIT_W)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (dig_inc[gi]),
                .load      (load_time),
                .load_val  (dig_load_val[gi]),
                .value     (dig_val[gi]),
                .carry_out (dig_carry[gi])
            );
        end
    endgenerate

    logic [HOUR_TENS_W-1:0] hour1_reg, hour1_next;
    logic [DIGIT_W-1:0]     hour0_reg, hour0_next;
    logic [HOUR_TENS_W-1:0] al_hour1_reg, al_hour1_next;
    logic [DIGIT_W-1:0]     al_hour0_reg, al_hour0_next;
    logic [DIGIT_W-1:0]     al_min1_reg, al_min1_next;
    logic [DIGIT_W-1:0]     al_min0_reg, al_min0_next;

    // Hour pair handled jointly so 23 wraps straight to 00.
    always_comb begin
        hour1_next = hour1_reg;
        hour0_next = hour0_reg;
        if (load_time) begin
            hour1_next = H_in1;
            hour0_next = H_in0;
        end else if (dig_carry[3]) begin
            if (hour1_reg == HOUR_TENS_W'(HOUR_TENS_MAX) &&
                hour0_reg == DIGIT_W'(HOUR_UNITS_MAX_AT_20)) begin
                hour1_next = '0;
                hour0_next = '0;
            end else if (hour0_reg == DIGIT_W'(DIGIT_MAX)) begin
                hour1_next = hour1_reg + HOUR_TENS_W'(1);
                hour0_next = '0;
            end else begin
                hour0_next = hour0_reg + DIGIT_W'(1);
            end
        end
    end

    always_comb begin
        al_hour1_next = al_hour1_reg;
        al_hour0_next = al_hour0_reg;
        al_min1_next  = al_min1_reg;
        al_min0_next  = al_min0_reg;
        if (load_alarm) begin
            al_hour1_next = H_in1;
            al_hour0_next = H_in0;
            al_min1_next  = M_in1;
            al_min0_next  = M_in0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_reg    <= '0;
            one_sec_reg  <= 1'b0;
            ld_err_reg   <= 1'b0;
            hour1_reg    <= '0;
            hour0_reg    <= '0;
            al_hour1_reg <= '0;
            al_hour0_reg <= '0;
            al_min1_reg  <= '0;
            al_min0_reg  <= '0;
        end else begin
            presc_reg    <= presc_next;
            one_sec_reg  <= one_sec_next;
            ld_err_reg   <= ld_err_next;
            hour1_reg    <= hour1_next;
            hour0_reg    <= hour0_next;
            al_hour1_reg <= al_hour1_next;
            al_hour0_reg <= al_hour0_next;
            al_min1_reg  <= al_min1_next;
            al_min0_reg  <= al_min0_next;
        end
    end

    assign c_hour1 = hour1_reg;
    assign c_hour0 = hour0_reg;
    assign c_min1  = dig_val[3];
    assign c_min0  = dig_val[2];
    assign c_sec1  = dig_val[1];
    assign c_sec0  = dig_val[0];
    assign a_hour1 = al_hour1_reg;
    assign a_hour0 = al_hour0_reg;
    assign a_min1  = al_min1_reg;
    assign a_min0  = al_min0_reg;
    assign one_sec = one_sec_reg;
    assign ld_err  = ld_err_reg;

endmodule

// File: tb/tb_time_keeper.sv
// Directed scoreboard bench for time_keeper: stimulus queues expected
// snapshots, a negedge monitor pops and compares them.
module tb_time_keeper;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] H_in1 = '0;
    logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;
    logic       LD_time = 1'b0, LD_alarm = 1'b0;
    logic [1:0] c_hour1, a_hour1;
    logic [3:0] c_hour0, c_min1, c_min0, c_sec1, c_sec0;
    logic [3:0] a_hour0, a_min1, a_min0;
    logic       one_sec, ld_err;

    time_keeper #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .c_hour1  (c_hour1),
        .c_hour0  (c_hour0),
        .c_min1   (c_min1),
        .c_min0   (c_min0),
        .c_sec1   (c_sec1),
        .c_sec0   (c_sec0),
        .a_hour1  (a_hour1),
        .a_hour0  (a_hour0),
        .a_min1   (a_min1),
        .a_min0   (a_min0),
        .one_sec  (one_sec),
        .ld_err   (ld_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          kind;   // 0 time, 1 alarm, 2 flags {one_sec, ld_err}
        logic [21:0] exp;
        int          due;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [21:0] tv(input int hh, input int mm, input int ss);
        return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [21:0] av(input int hh, input int mm);
        return {8'd0, 2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    task automatic exp_time(input string n, input int hh, input int mm, input int ss);
        sb.push_back('{n, 0, tv(hh, mm, ss), cyc});
    endtask

    task automatic exp_alarm(input string n, input int hh, input int mm);
        sb.push_back('{n, 1, av(hh, mm), cyc});
    endtask

    task automatic exp_flags(input string n, input logic os, input logic le);
        sb.push_back('{n, 2, {20'd0, os, le}, cyc});
    endtask

    // Monitor: compares every expectation that has come due.
    sb_t         mon_e;
    logic [21:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                0:       mon_act = {c_hour1, c_hour0, c_min1, c_min0, c_sec1, c_sec0};
                1:       mon_act = {8'd0, a_hour1, a_hour0, a_min1, a_min0};
                default: mon_act = {20'd0, one_sec, ld_err};
            endcase
            checks++;
            if (mon_act !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got %h required %h (cycle %0d)", mon_e.name, mon_act, mon_e.exp, cyc);
            end else begin
                $display("ok   %s: %h (cycle %0d)", mon_e.name, mon_act, cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input int h1, input int h0, input int m1, input int m0);
        H_in1 = 2'(h1);
        H_in0 = 4'(h0);
        M_in1 = 4'(m1);
        M_in0 = 4'(m0);
    endtask

    task automatic load_time(input int h1, input int h0, input int m1, input int m0);
        set_raw(h1, h0, m1, m0);
        LD_time = 1'b1;
        step(1);
        LD_time = 1'b0;
    endtask

    // Rejected load issued with the prescaler at 0; time must keep its pace.
    task automatic bad_load(input string n, input logic alarm_sel,
                            input int h1, input int h0, input int m1, input int m0,
                            input int sec_before);
        set_raw(h1, h0, m1, m0);
        LD_time  = !alarm_sel;
        LD_alarm = alarm_sel;
        step(1);
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        exp_flags({n, "_err"}, 1'b0, 1'b1);
        exp_time({n, "_time_kept"}, 12, 34, sec_before);
        exp_alarm({n, "_alarm_kept"}, 12, 34);
        step(1);
        exp_flags({n, "_err_one_cycle"}, 1'b0, 1'b0);
        step(2);
        exp_time({n, "_still_ticking"}, 12, 34, sec_before + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        step(3);
        exp_time("reset_time", 0, 0, 0);
        exp_alarm("reset_alarm", 0, 0);
        exp_flags("reset_flags", 1'b0, 1'b0);
        reset = 1'b1;
        step(2);
        exp_flags("no_tick_yet", 1'b0, 1'b0);
        step(1);
        exp_flags("first_tick", 1'b1, 1'b0);
        exp_time("before_first_sec", 0, 0, 0);
        step(1);
        exp_time("first_sec", 0, 0, 1);
        exp_flags("tick_one_cycle", 1'b0, 1'b0);

        // Full-day wrap
        load_time(2, 3, 5, 9);
        exp_time("load_2359", 23, 59, 0);
        step(CLK_DIV * 59);
        exp_time("at_235959", 23, 59, 59);
        step(CLK_DIV - 1);
        exp_time("hold_235959", 23, 59, 59);
        step(1);
        exp_time("day_wrap", 0, 0, 0);

        // Hour carries
        load_time(0, 9, 5, 9);
        step(CLK_DIV * 60);
        exp_time("carry_0959", 10, 0, 0);
        load_time(1, 9, 5, 9);
        step(CLK_DIV * 60);
        exp_time("carry_1959", 20, 0, 0);

        // Alarm load leaves time running
        set_raw(1, 2, 3, 4);
        LD_alarm = 1'b1;
        step(1);
        LD_alarm = 1'b0;
        exp_alarm("alarm_1234", 12, 34);
        exp_time("alarm_no_time_effect", 20, 0, 0);
        step(CLK_DIV - 1);
        exp_time("time_after_alarm", 20, 0, 1);
        load_time(1, 2, 3, 4);
        exp_time("time_1234", 12, 34, 0);
        exp_alarm("alarm_still_1234", 12, 34);

        // Rejected entries
        bad_load("bad_2400", 1'b0, 2, 4, 0, 0, 0);
        bad_load("bad_1360", 1'b0, 1, 3, 6, 0, 1);
        bad_load("bad_h0_10", 1'b0, 0, 10, 0, 0, 2);
        bad_load("bad_alarm_24", 1'b1, 2, 4, 0, 5, 3);

        // LD_time in the tick cycle
        step(CLK_DIV - 1);
        exp_flags("tick_cycle", 1'b1, 1'b0);
        set_raw(0, 5, 3, 0);
        LD_time = 1'b1;
        step(1);
        LD_time = 1'b0;
        exp_time("collide_load", 5, 30, 0);
        exp_flags("collide_flags", 1'b0, 1'b0);
        step(CLK_DIV - 1);
        exp_flags("collide_next_tick", 1'b1, 1'b0);
        exp_time("collide_pre_adv", 5, 30, 0);
        step(1);
        exp_time("collide_adv", 5, 30, 1);

        // Held LD_time freezes time
        set_raw(0, 1, 0, 2);
        LD_time = 1'b1;
        step(6);
        exp_time("held_load", 1, 2, 0);
        exp_flags("held_no_tick", 1'b0, 1'b0);
        LD_time = 1'b0;
        step(CLK_DIV - 1);
        exp_flags("held_release_tick", 1'b1, 1'b0);
        step(1);
        exp_time("held_release_adv", 1, 2, 1);

        // Both loads together
        set_raw(0, 7, 1, 5);
        LD_time  = 1'b1;
        LD_alarm = 1'b1;
        step(1);
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        exp_time("both_time", 7, 15, 0);
        exp_alarm("both_alarm", 7, 15);

        // Reset beats load
        set_raw(1, 1, 1, 1);
        reset   = 1'b0;
        LD_time = 1'b1;
        step(1);
        exp_time("reset_vs_load_time", 0, 0, 0);
        exp_alarm("reset_vs_load_alarm", 0, 0);
        exp_flags("reset_vs_load_flags", 1'b0, 1'b0);
        LD_time = 1'b0;
        reset   = 1'b1;

        step(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
